eip_redirect_ctrl: RTL

Parametrised next-generation EIP register and redirect controller for the writeback stage.
- Holds the architectural EIP; advances it from decode or redirects it from writeback.
- Redirect target is chosen from NCH ALU result channels, gated by a generalised NFLAG flag-condition check.
- Adds a redirect handshake FSM toward fetch; decode advance is suppressed until fetch accepts the new EIP.

---
 rtl/eip_redirect_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/eip_redirect_ctrl.sv
// Architectural EIP register with writeback redirect, flag-gated target select and fetch handshake FSM.
// Optional taken-redirect counter output redir_cnt is enabled by defining REDIR_CNT_EN.
module eip_redirect_ctrl #(
  parameter int                   EIP_W     = 32,
  parameter int                   NCH       = 2,
  parameter int                   SEL_W     = 1,
  parameter int                   NFLAG     = 2,
  parameter logic [EIP_W-1:0]     RESET_EIP = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_v,
  input  logic                    wb_eip_change,
  input  logic [NCH*EIP_W-1:0]    wb_alu_res,
  input  logic [SEL_W-1:0]        wb_res_sel,
  input  logic [EIP_W-1:0]        wb_eip_next,
  input  logic [NFLAG-1:0]        wb_cond_en,
  input  logic [NFLAG-1:0]        wb_flag,
  input  logic [NFLAG-1:0]        wb_flag_exp,
  input  logic                    wb_size16,
  input  logic                    de_v,
  input  logic                    de_stall,
  input  logic                    de_br_stall,
  input  logic [EIP_W-1:0]        de_eip_next,
  input  logic                    fe_redir_rdy,
  output logic [EIP_W-1:0]        eip,
  output logic [1:0]              ld_eip,
  output logic                    fe_redir_v,
  output logic [EIP_W-1:0]        fe_redir_eip,
  output logic                    redir_busy
`ifdef REDIR_CNT_EN
  ,
  output logic [15:0]             redir_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [EIP_W-1:0]  eip_q, eip_d;
  logic [EIP_W-1:0]  fe_eip_q, fe_eip_d;
  logic [EIP_W-1:0]  chan;
  logic [EIP_W-1:0]  tgt;
  logic              cond_met;
  logic              redirect;
  logic              advance;

  // Out-of-range selects fall back to channel 0.
  always_comb begin
    chan = wb_alu_res[EIP_W-1:0];
    for (int i = 0; i < NCH; i++) begin
      if (32'(wb_res_sel) == i) chan = wb_alu_res[i*EIP_W +: EIP_W];
    end
  end

  always_comb begin
    cond_met = 1'b1;
    for (int i = 0; i < NFLAG; i++) begin
      if (wb_cond_en[i] && (wb_flag[i] != wb_flag_exp[i])) cond_met = 1'b0;
    end
  end

  always_comb begin
    tgt = cond_met ? chan : wb_eip_next;
    if (wb_size16) tgt[EIP_W-1:16] = '0;
  end

  assign redirect = wb_v & wb_eip_change;
  assign advance  = de_v & ~de_stall & ~de_br_stall & (state_q == IDLE);
  assign ld_eip   = {redirect, advance};

  always_comb begin
    eip_d    = eip_q;
    fe_eip_d = fe_eip_q;
    if (redirect) begin
      eip_d    = tgt;
      fe_eip_d = tgt;
    end else if (advance) begin
      eip_d    = de_eip_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      eip_q    <= RESET_EIP;
      fe_eip_q <= RESET_EIP;
    end else begin
      state_q  <= state_d;
      eip_q    <= eip_d;
      fe_eip_q <= fe_eip_d;
    end
  end

  // A newer redirect while waiting on fetch replaces the pending target.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (redirect) state_d = REDIR;
      REDIR:   if (!redirect && fe_redir_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fe_redir_v = (state_q == REDIR);
    redir_busy = (state_q == REDIR);
  end

  assign eip          = eip_q;
  assign fe_redir_eip = fe_eip_q;

`ifdef REDIR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (redirect && cond_met) ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign redir_cnt = cnt_q;
`endif

endmodule
